// File: rtl/fb_bank_ctrl_if.sv
// Host pixel-write channel into the frame-buffer bank controller.
// The host (master) holds a request until wr_ready_o is seen high with wr_valid_i.
interface fb_bank_ctrl_if #(
  parameter int AW = 16,
  parameter int DW = 24
);
  logic          wr_valid_i;
  logic [AW-1:0] wr_addr_i;
  logic [DW-1:0] wr_data_i;
  logic          wr_ready_o;

  modport master (output wr_valid_i, wr_addr_i, wr_data_i, input wr_ready_o);
  modport slave  (input wr_valid_i, wr_addr_i, wr_data_i, output wr_ready_o);
endinterface

// File: rtl/fb_bank_ctrl.sv
// Double-buffered frame RAM bank controller: host writes go to the back bank,
// the scanner reads the front bank, and swaps are deferred to the end of a frame.
module fb_bank_ctrl #(
  parameter int AW = 16,
  parameter int DW = 24
) (
  input  logic          clk_i,
  input  logic          rst_i,
  fb_bank_ctrl_if.slave wr,
  input  logic          swap_req_i,
  input  logic          clear_req_i,
  input  logic          frame_done_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [AW:0]   ram_rd_addr_o,
  output logic          ram_wr_en_o,
  output logic [AW:0]   ram_wr_addr_o,
  output logic [DW-1:0] ram_wr_data_o,
  output logic          front_bank_o,
  output logic          busy_o,
  output logic          swap_ack_o
);
  typedef enum logic [1:0] {IDLE, CLEAR, SWAP_WAIT} state_t;

  state_t        state, state_nxt;
  logic          swap_pend, pend_nxt;
  logic          front_bank;
  logic [AW-1:0] clr_cnt;
  logic          wr_ready_q;
  logic          busy_q;
  logic          swap_ack_q;
  logic          do_swap;
  logic          clr_last;
  logic          host_acc;

  assign clr_last = (clr_cnt == {AW{1'b1}});
  // Ready is registered and only ever high in IDLE, so an accepted write
  // can never collide with a clear fill or land across a bank swap.
  assign host_acc = wr.wr_valid_i & wr_ready_q;

  always_comb begin
    state_nxt = state;
    pend_nxt  = swap_pend | swap_req_i;
    do_swap   = 1'b0;
    case (state)
      IDLE: begin
        if (clear_req_i)                  state_nxt = CLEAR;
        else if (swap_req_i || swap_pend) state_nxt = SWAP_WAIT;
      end
      CLEAR: begin
        if (clr_last) state_nxt = IDLE;
      end
      SWAP_WAIT: begin
        // A swap request landing on the swap cycle is absorbed into this swap.
        if (frame_done_i) begin
          do_swap   = 1'b1;
          pend_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      swap_pend     <= 1'b0;
      front_bank    <= 1'b0;
      clr_cnt       <= '0;
      wr_ready_q    <= 1'b0;
      busy_q        <= 1'b0;
      swap_ack_q    <= 1'b0;
      ram_wr_en_o   <= 1'b0;
      ram_wr_addr_o <= '0;
      ram_wr_data_o <= '0;
    end else begin
      state      <= state_nxt;
      swap_pend  <= pend_nxt;
      swap_ack_q <= do_swap;
      wr_ready_q <= (state_nxt == IDLE) && !pend_nxt;
      busy_q     <= (state_nxt != IDLE) || pend_nxt;
      if (do_swap) front_bank <= ~front_bank;
      clr_cnt     <= (state == CLEAR) ? clr_cnt + 1'b1 : '0;
      ram_wr_en_o <= 1'b0;
      if (state == CLEAR) begin
        ram_wr_en_o   <= 1'b1;
        ram_wr_addr_o <= {~front_bank, clr_cnt};
        ram_wr_data_o <= '0;
      end else if (host_acc) begin
        ram_wr_en_o   <= 1'b1;
        ram_wr_addr_o <= {~front_bank, wr.wr_addr_i};
        ram_wr_data_o <= wr.wr_data_i;
      end
    end
  end

  assign wr.wr_ready_o   = wr_ready_q;
  assign busy_o          = busy_q;
  assign swap_ack_o      = swap_ack_q;
  assign front_bank_o    = front_bank;
  assign ram_rd_addr_o   = {front_bank, rd_addr_i};
endmodule
